mem_burst_master: RTL and testbench
===================================

// Module: mem_burst_master
// PURPOSE
//  Initiator side of the dataMemory port (addr/writeData/write/readData). Accepts one
//  burst command (read or write, start address, length) over a valid/ready handshake,
//  then drives the memory one beat at a time: streams write data in, or read data out
//  with backpressure. Sits between the datapath/DMA logic and dataMemory.
// PARAMETERS
//  ADDR_W  8  memory address width; addresses wrap modulo 2**ADDR_W
//  DATA_W  8  memory data width
//  LEN_W   4  burst length field; beats = req_len+1 (1..2**LEN_W)
//  RD_LAT  1  cycles from mem_addr valid to mem_rdata valid (legal: 0 or 1)
// PORTS
//  sysclk     in   1       clock, all state on rising edge
//  rst        in   1       asynchronous, active-high reset
//  req_valid  in   1       command valid
//  req_ready  out  1       command accepted when valid&&ready
//  req_write  in   1       1=write burst, 0=read burst
//  req_addr   in   ADDR_W  burst start address
//  req_len    in   LEN_W   beats-1
//  wr_data    in   DATA_W  write beat data
//  wr_valid   in   1       write beat valid
//  wr_ready   out  1       write beat accepted when valid&&ready
//  rd_data    out  DATA_W  read beat data (registered)
//  rd_valid   out  1       read beat valid; held until rd_ready
//  rd_ready   in   1       read consumer ready
//  rd_last    out  1       qualifies final read beat
//  busy       out  1       burst in progress (state!=IDLE)
//  done       out  1       1-cycle pulse after final beat completes
//  mem_addr   out  ADDR_W  to dataMemory.addr
//  mem_wdata  out  DATA_W  to dataMemory.writeData
//  mem_write  out  1       to dataMemory.write (memory writes on sysclk edge)
//  mem_rdata  in   DATA_W  from dataMemory.readData
// BEHAVIOUR
//  - Reset: state=IDLE; req_ready=1 once released; wr_ready, rd_valid, rd_last, busy,
//    done, mem_write=0; rd_data, mem_addr, mem_wdata=0; beat counter=0.
//  - FSM: IDLE -> WR (req_write) | RD_ISSUE (!req_write) on req handshake; captures
//    addr_q=req_addr, cnt_q=req_len. req_ready=1 only in IDLE; requests ignored otherwise.
//  - WR: wr_ready=1; mem_addr=addr_q; mem_wdata=wr_data; mem_write=wr_valid (comb).
//    Each accepted beat: addr_q+1 (wraps 0xFF->0x00), cnt_q-1; beat with cnt_q==0 ->
//    IDLE, done pulses next cycle. wr_valid low = stall, no write issued.
//  - RD_ISSUE: mem_addr=addr_q, mem_write=0. RD_LAT=0: capture mem_rdata same cycle ->
//    RD_HOLD. RD_LAT=1: -> RD_WAIT (one cycle, addr held), capture -> RD_HOLD.
//  - RD_HOLD: rd_valid=1, rd_data stable, rd_last=(cnt_q==0). On rd_ready: if last ->
//    IDLE + done; else addr_q+1, cnt_q-1 -> RD_ISSUE. Min 2 (RD_LAT=0) / 3 cycles/beat.
//  - mem_write is never 1 outside WR; never 1 in the cycle rst is high.
//  - Reset mid-burst: burst aborted immediately, no further memory writes, no done,
//    pending rd_valid dropped; next command starts cleanly.
//  - done and req_handshake cannot coincide (req_ready low while done is computed).
//  - Length wrap: req_len=2**LEN_W-1 gives 16 beats; address wrap is independent of length.
// STRUCTURE
//  - Shared package mem_pkg: ADDR_W/DATA_W defaults, state enum
//    {IDLE, WR, RD_ISSUE, RD_WAIT, RD_HOLD}, beat-count type.
//  - Single module; no sub-module. Address/count registers inline.
// TESTING (bench instantiates mem_burst_master + dataMemory)
//  1. Reset then write burst addr=0x00 len=3, data 55,AA,0F,F0 back-to-back ->
//     4 mem_write cycles at 00..03, done pulse once; memory holds 55,AA,0F,F0.
//  2. Read burst addr=0x00 len=3, rd_ready=1 -> rd_data 55,AA,0F,F0, rd_last on F0, done.
//  3. Read len=1 with rd_ready low 5 cycles on beat 0 -> rd_valid/rd_data held stable,
//     mem_addr not advanced; completes after rd_ready rises.
//  4. Write burst addr=0xFE len=2 data 11,22,33 -> writes to FE,FF,00 (wrap).
//  5. Write len=3, wr_valid gaps of 2 cycles between beats -> exactly 4 writes, no
//     mem_write during gaps; req_valid pulsed mid-burst is not accepted (req_ready=0).
//  6. Assert rst after beat 1 of a 4-beat write -> mem_write=0 immediately, locations
//     02,03 unchanged, no done, busy=0; a following read burst works normally.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared definitions for the burst master on the dataMemory port:
// default widths, the controller state encoding and the beat-count type.
package mem_pkg;

  localparam int ADDR_W_DEF = 8;
  localparam int DATA_W_DEF = 8;
  localparam int LEN_W_DEF  = 4;
  localparam int RD_LAT_DEF = 1;

  // Controller states; IDLE is the only state in which a command is taken.
  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WR       = 3'd1,
    RD_ISSUE = 3'd2,
    RD_WAIT  = 3'd3,
    RD_HOLD  = 3'd4
  } state_t;

  // Remaining beats minus one for the default length width.
  typedef logic [LEN_W_DEF-1:0] beat_cnt_t;

  // Number of beats a length field describes (len + 1).
  function automatic int unsigned beats_of(input beat_cnt_t len);
    return int'(len) + 1;
  endfunction

endpackage

// File: rtl/mem_burst_master.sv
// Burst initiator for the dataMemory port. One command (read or write,
// start address, beats-1) is accepted in IDLE; the burst is then driven
// one beat at a time. Write data streams straight to the memory, read data
// is registered and held towards the consumer until it is taken.
//
// Handshakes: every channel (req, wr, rd) transfers on a rising sysclk edge
// where valid && ready are both high. A source holds valid and its payload
// stable until the transfer; ready may change freely between transfers.
// rd_valid/rd_data/rd_last are only released after rd_ready is seen high.
module mem_burst_master
  import mem_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int LEN_W  = LEN_W_DEF,
  parameter int RD_LAT = RD_LAT_DEF   // 0: combinational read, 1: registered read
) (
  input  logic              sysclk,
  input  logic              rst,
  // command channel
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [LEN_W-1:0]  req_len,
  // write beat channel
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_valid,
  output logic              wr_ready,
  // read beat channel
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic              rd_last,
  // status
  output logic              busy,
  output logic              done,
  // memory side
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_write,
  input  logic [DATA_W-1:0] mem_rdata,
  // debug view of the controller state
  output logic [2:0]        dbg_state
);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LEN_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              done_q, done_d;

  logic              last_beat;
  logic              wr_beat;
  logic              rd_beat;

  // The current beat is the final one once the remaining count reaches zero.
  assign last_beat = (cnt_q == '0);
  assign wr_beat   = (state_q == WR) && wr_valid;
  assign rd_beat   = (state_q == RD_HOLD) && rd_ready;

  // State, address, count and read-data registers; reset aborts any burst.
  always_ff @(posedge sysclk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      cnt_q     <= '0;
      rd_data_q <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      cnt_q     <= cnt_d;
      rd_data_q <= rd_data_d;
      done_q    <= done_d;
    end
  end

  // Next-state logic: command capture, beat stepping and read capture.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    cnt_d     = cnt_q;
    rd_data_d = rd_data_q;
    done_d    = 1'b0;
    case (state_q)
      IDLE: begin
        // done_q blocks a new command in the pulse cycle so the two never coincide.
        if (req_valid && !done_q) begin
          state_d = req_write ? WR : RD_ISSUE;
          addr_d  = req_addr;
          cnt_d   = req_len;
        end
      end
      WR: begin
        if (wr_beat) begin
          addr_d = addr_q + ADDR_W'(1);
          if (last_beat) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            cnt_d = cnt_q - LEN_W'(1);
          end
        end
      end
      RD_ISSUE: begin
        if (RD_LAT == 0) begin
          rd_data_d = mem_rdata;
          state_d   = RD_HOLD;
        end else begin
          state_d = RD_WAIT;
        end
      end
      RD_WAIT: begin
        // Address has been held for one cycle; registered read data is valid now.
        rd_data_d = mem_rdata;
        state_d   = RD_HOLD;
      end
      RD_HOLD: begin
        if (rd_beat) begin
          if (last_beat) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            addr_d  = addr_q + ADDR_W'(1);
            cnt_d   = cnt_q - LEN_W'(1);
            state_d = RD_ISSUE;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Interface outputs decoded from the registered state.
  always_comb begin
    req_ready = (state_q == IDLE) && !done_q && !rst;
    wr_ready  = (state_q == WR);
    rd_valid  = (state_q == RD_HOLD);
    rd_last   = (state_q == RD_HOLD) && last_beat;
    rd_data   = rd_data_q;
    busy      = (state_q != IDLE);
    done      = done_q;
    mem_addr  = addr_q;
    mem_wdata = (state_q == WR) ? wr_data : '0;
    // Gating with rst keeps the memory from writing in the cycle reset rises.
    mem_write = wr_beat && !rst;
    dbg_state = state_q;
  end

endmodule

// File: tb/tb_mem_burst_master.sv
// Bench for mem_burst_master with a registered-read dataMemory model.
// A reference memory and per-beat expectation queues describe what the
// memory port and read channel must show; one negedge process compares.
module tb_mem_burst_master;
  import mem_pkg::*;

  localparam int AW = 8;
  localparam int DW = 8;
  localparam int LW = 4;

  logic          sysclk = 1'b0;
  logic          rst = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_write = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [LW-1:0] req_len = '0;
  logic [DW-1:0] wr_data = '0;
  logic          wr_valid = 1'b0;
  logic          wr_ready;
  logic [DW-1:0] rd_data;
  logic          rd_valid;
  logic          rd_ready = 1'b0;
  logic          rd_last;
  logic          busy;
  logic          done;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_write;
  logic [DW-1:0] mem_rdata = '0;
  logic [2:0]    dbg_state;

  int checks = 0;
  int failures = 0;

  // ---------------- clock / reset ----------------
  always #5 sysclk = ~sysclk;

  mem_burst_master #(.ADDR_W(AW), .DATA_W(DW), .LEN_W(LW), .RD_LAT(1)) dut (
    .sysclk(sysclk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_len(req_len),
    .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_last(rd_last),
    .busy(busy), .done(done),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_write(mem_write),
    .mem_rdata(mem_rdata), .dbg_state(dbg_state)
  );

  // dataMemory: synchronous write, one-cycle registered read.
  logic [DW-1:0] mem [256] = '{default: '0};
  always @(posedge sysclk) begin
    if (mem_write) mem[mem_addr] <= mem_wdata;
    mem_rdata <= mem[mem_addr];
  end

  // ---------------- reference model ----------------
  logic [DW-1:0] ref_mem [256] = '{default: '0};
  logic [16:0]   exp_wr_q[$];   // {last, addr, data}
  logic [8:0]    exp_rd_q[$];   // {last, data}
  logic [DW-1:0] wq[$];         // write data for the next write burst
  int            exp_done_total = 0;
  int            done_seen = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    failures++;
    $display("FAIL %s: timeout at %0t", name, $time);
  endtask

  // ---------------- scoreboard / compare process ----------------
  bit            pend_done = 1'b0;
  bit            hold_v = 1'b0;
  logic [DW-1:0] hold_d = '0;

  always @(negedge sysclk) begin
    bit            nxt_pend;
    logic [16:0]   ew;
    logic [8:0]    er;
    nxt_pend = 1'b0;
    if (rst) begin
      chk("rst_mem_write", mem_write, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_rd_valid", rd_valid, 0);
      chk("rst_wr_ready", wr_ready, 0);
      hold_v = 1'b0;
    end else begin
      chk("done_timing", done, pend_done);
      if (done) done_seen++;
      chk("req_ready_idle", req_ready, !busy && !done);
      chk("rd_last_qual", rd_last && !rd_valid, 0);
      if (mem_write) begin
        chk("write_in_wr", wr_ready, 1);
        if (exp_wr_q.size() == 0) begin
          timeout("unexpected_write");
        end else begin
          ew = exp_wr_q.pop_front();
          chk("wr_addr", mem_addr, ew[15:8]);
          chk("wr_data", mem_wdata, ew[7:0]);
          if (ew[16]) nxt_pend = 1'b1;
        end
      end
      if (hold_v) begin
        chk("rd_hold_valid", rd_valid, 1);
        chk("rd_hold_data", rd_data, hold_d);
      end
      if (rd_valid && rd_ready) begin
        if (exp_rd_q.size() == 0) begin
          timeout("unexpected_read");
        end else begin
          er = exp_rd_q.pop_front();
          chk("rd_data", rd_data, er[7:0]);
          chk("rd_last", rd_last, er[8]);
          if (er[8]) nxt_pend = 1'b1;
        end
      end
      hold_v = rd_valid && !rd_ready;
      hold_d = rd_data;
    end
    pend_done = nxt_pend;
  end

  // ---------------- driver tasks ----------------
  task automatic issue_cmd(input bit w, input logic [AW-1:0] a, input logic [LW-1:0] l);
    bit got;
    got = 1'b0;
    req_write = w;
    req_addr  = a;
    req_len   = l;
    req_valid = 1'b1;
    for (int c = 0; c < 50 && !got; c++) begin
      @(negedge sysclk);
      got = req_ready;
      @(posedge sysclk);
      #1;
    end
    req_valid = 1'b0;
    req_addr  = AW'($urandom);
    if (!got) timeout("req_accept");
  endtask

  // abort_after < 0: full burst; otherwise reset after that many beats.
  task automatic run_write(input logic [AW-1:0] a, input logic [LW-1:0] l,
                           input int gap_lo, input int gap_hi,
                           input int abort_after, input bit pulse_req);
    int n;
    int i;
    int gap_left;
    int cyc;
    bit acc;
    logic [AW-1:0] ai;
    n = int'(l) + 1;
    for (int k = 0; k < n; k++) begin
      if (abort_after < 0 || k < abort_after) begin
        ai = a + AW'(k);
        exp_wr_q.push_back({(k == n - 1), ai, wq[k]});
        ref_mem[ai] = wq[k];
      end
    end
    if (abort_after < 0) exp_done_total++;
    issue_cmd(1'b1, a, l);
    i = 0;
    gap_left = 0;
    cyc = 0;
    while (i < n && cyc < 300) begin
      if (abort_after >= 0 && i == abort_after) break;
      if (gap_left > 0) begin
        wr_valid  = 1'b0;
        wr_data   = DW'($urandom);
        req_valid = pulse_req;
      end else begin
        wr_valid = 1'b1;
        wr_data  = wq[i];
      end
      @(negedge sysclk);
      acc = wr_valid && wr_ready;
      if (req_valid) chk("req_mid_burst", req_ready, 0);
      @(posedge sysclk);
      #1;
      req_valid = 1'b0;
      if (acc) begin
        i++;
        gap_left = $urandom_range(gap_lo, gap_hi);
      end else if (gap_left > 0) begin
        gap_left--;
      end
      cyc++;
    end
    if (abort_after >= 0 && i == abort_after) begin
      rst      = 1'b1;
      wr_valid = 1'b1;
      wr_data  = wq[i];
      @(negedge sysclk);
      chk("abort_mem_write", mem_write, 0);
      chk("abort_busy", busy, 0);
      @(posedge sysclk);
      #1;
      @(posedge sysclk);
      #1;
      wr_valid = 1'b0;
      rst      = 1'b0;
    end else if (i < n) begin
      timeout("write_beats");
    end
    wr_valid = 1'b0;
    wq.delete();
    repeat (2) begin
      @(posedge sysclk);
      #1;
    end
  endtask

  task automatic run_read(input logic [AW-1:0] a, input logic [LW-1:0] l,
                          input int stall0, input bit rnd);
    int n;
    int got;
    int stalled;
    int cyc;
    logic [AW-1:0] ai;
    n = int'(l) + 1;
    for (int k = 0; k < n; k++) begin
      ai = a + AW'(k);
      exp_rd_q.push_back({(k == n - 1), ref_mem[ai]});
    end
    exp_done_total++;
    issue_cmd(1'b0, a, l);
    got = 0;
    stalled = 0;
    cyc = 0;
    while (got < n && cyc < 600) begin
      if (got == 0 && stalled < stall0) rd_ready = 1'b0;
      else rd_ready = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
      @(negedge sysclk);
      if (rd_valid && rd_ready) begin
        got++;
      end else if (got == 0 && rd_valid && stalled < stall0) begin
        chk("stall_addr", mem_addr, a);
        stalled++;
      end
      @(posedge sysclk);
      #1;
      cyc++;
    end
    rd_ready = 1'b0;
    if (got < n) timeout("read_beats");
    repeat (2) begin
      @(posedge sysclk);
      #1;
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [DW-1:0] old2;
    logic [DW-1:0] old3;
    // reset
    repeat (3) @(posedge sysclk);
    #1;
    rst = 1'b0;
    @(negedge sysclk);
    chk("rel_req_ready", req_ready, 1);
    chk("rel_mem_addr", mem_addr, 0);
    chk("rel_mem_wdata", mem_wdata, 0);
    chk("rel_rd_data", rd_data, 0);
    chk("rel_state", dbg_state, 32'(IDLE));
    @(posedge sysclk);
    #1;

    // 1: write 55,AA,0F,F0 at 00..03
    wq = '{8'h55, 8'hAA, 8'h0F, 8'hF0};
    run_write(8'h00, 4'd3, 0, 0, -1, 1'b0);
    chk("t1_mem0", mem[0], 8'h55);
    chk("t1_mem1", mem[1], 8'hAA);
    chk("t1_mem2", mem[2], 8'h0F);
    chk("t1_mem3", mem[3], 8'hF0);

    // 2: read it back with rd_ready held high
    run_read(8'h00, 4'd3, 0, 1'b0);

    // 3: two-beat read, consumer stalls 5 cycles on beat 0
    run_read(8'h00, 4'd1, 5, 1'b0);

    // 4: address wrap FE,FF,00
    wq = '{8'h11, 8'h22, 8'h33};
    run_write(8'hFE, 4'd2, 0, 0, -1, 1'b0);
    chk("t4_memFE", mem[8'hFE], 8'h11);
    chk("t4_memFF", mem[8'hFF], 8'h22);
    chk("t4_mem00", mem[8'h00], 8'h33);

    // 5: two-cycle wr_valid gaps with a stray command pulse in the gaps
    wq = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
    run_write(8'h40, 4'd3, 2, 2, -1, 1'b1);

    // 6: reset after beat 1 of a four-beat write, then a normal read
    old2 = ref_mem[2];
    old3 = ref_mem[3];
    wq = '{8'h5A, 8'h6B, 8'h7C, 8'h8D};
    run_write(8'h00, 4'd3, 0, 0, 2, 1'b0);
    chk("t6_mem2_kept", mem[2], old2);
    chk("t6_mem3_kept", mem[3], old3);
    chk("t6_mem0", mem[0], 8'h5A);
    chk("t6_mem1", mem[1], 8'h6B);
    chk("t6_wr_q_empty", exp_wr_q.size(), 0);
    run_read(8'h00, 4'd3, 0, 1'b0);

    // full-length burst (16 beats) across the address wrap
    for (int k = 0; k < 16; k++) wq.push_back(DW'($urandom));
    run_write(8'hF8, 4'd15, 0, 1, -1, 1'b0);
    run_read(8'hF8, 4'd15, 0, 1'b1);

    // randomized bursts
    for (int t = 0; t < 40; t++) begin
      logic [AW-1:0] ra;
      logic [LW-1:0] rl;
      ra = AW'($urandom_range(0, 255));
      rl = LW'($urandom_range(0, 15));
      if ($urandom_range(0, 1) == 1) begin
        for (int k = 0; k <= int'(rl); k++) wq.push_back(DW'($urandom));
        run_write(ra, rl, 0, 2, -1, 1'b0);
      end else begin
        run_read(ra, rl, $urandom_range(0, 3), 1'b1);
      end
    end

    // final report
    repeat (3) @(posedge sysclk);
    #1;
    chk("end_wr_q", exp_wr_q.size(), 0);
    chk("end_rd_q", exp_rd_q.size(), 0);
    chk("done_count", done_seen, exp_done_total);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
